zstr_arb: RTL

ZSTR_ARB -- requirements
Module: zstr_arb

---
 rtl/zstr_arb_pkg.sv | 9 +
 rtl/zstr_arb_rr.sv | 44 ++++
 rtl/zstr_arb.sv | 131 +++++++++++++
 3 files changed

// File: rtl/zstr_arb_pkg.sv
// zstr_arb_pkg: helpers shared by the z-stream arbiter and its priority encoder.
//   idx_width(n) - width of an index able to address n sources, never below 1.
package zstr_arb_pkg;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/zstr_arb_rr.sv
// zstr_arb_rr: combinational rotate-priority encoder.
// Grants the first requester found when searching upward from ptr_i, wrapping SN-1 -> 0.
// Ports:
//   req_i  - request vector, one bit per source
//   ptr_i  - index where the search starts
//   gnt_o  - one-hot grant, all zeros when nothing requests
//   idx_o  - index of the granted source (0 when nothing requests)
module zstr_arb_rr
    import zstr_arb_pkg::*;
#(
    parameter int unsigned SN = 2,
    localparam int unsigned SW = idx_width(SN)
) (
    input  logic [SN-1:0] req_i,
    input  logic [SW-1:0] ptr_i,
    output logic [SN-1:0] gnt_o,
    output logic [SW-1:0] idx_o
);

    int unsigned k;
    logic [SW-1:0] kk;
    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        k     = 0;
        kk    = '0;
        for (int unsigned off = 0; off < SN; off++) begin
            k = 32'(ptr_i) + off;
            if (k >= SN) begin
                k = k - SN;
            end
            kk = SW'(k);
            if (!found && req_i[kk]) begin
                found     = 1'b1;
                gnt_o[kk] = 1'b1;
                idx_o     = kk;
            end
        end
    end

endmodule

// File: rtl/zstr_arb.sv
// zstr_arb: round-robin arbiter merging SN valid/ready z streams into one registered output.
// Optional packet lock (LK=1): bit BW-1 of the bus marks the last beat; a packet, once started,
// owns the output until its last beat has transferred.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   s_vld/s_rdy   - per-source handshake (SN bits)
//   s_bus         - per-source data, source i at [i*BW +: BW]
//   z_vld/z_rdy   - output handshake
//   z_bus         - output data, XZ on every bit while z_vld is low
//   z_sel         - source index of the data held in the output register
module zstr_arb
    import zstr_arb_pkg::*;
#(
    parameter int unsigned BW = 1,
    parameter logic        XZ = 1'bx,
    parameter int unsigned SN = 2,
    parameter bit          LK = 1'b0,
    localparam int unsigned SW = idx_width(SN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SN-1:0]    s_vld,
    input  logic [SN*BW-1:0] s_bus,
    output logic [SN-1:0]    s_rdy,
    output logic             z_vld,
    output logic [BW-1:0]    z_bus,
    input  logic             z_rdy,
    output logic [SW-1:0]    z_sel
);

    logic          z_vld_q, z_vld_d;
    logic [BW-1:0] z_bus_q, z_bus_d;
    logic [SW-1:0] z_sel_q, z_sel_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic          lock_q, lock_d;
    logic [SW-1:0] lck_idx_q, lck_idx_d;

    logic [SN-1:0] lck_mask;
    logic [SN-1:0] req;
    logic [SN-1:0] gnt;
    logic [SW-1:0] gnt_idx;
    logic          gnt_any;
    logic          load;
    logic          xfer;
    logic [BW-1:0] src_bus;

    // While locked, only the packet owner may request.
    always_comb begin
        lck_mask = '0;
        lck_mask[lck_idx_q] = 1'b1;
        req = lock_q ? (s_vld & lck_mask) : s_vld;
    end

    zstr_arb_rr #(
        .SN (SN)
    ) u_rr (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    // One-hot grant lets the data mux be a plain AND-OR.
    always_comb begin
        src_bus = '0;
        for (int unsigned i = 0; i < SN; i++) begin
            src_bus = src_bus | (s_bus[i*BW +: BW] & {BW{gnt[i]}});
        end
    end

    assign gnt_any = |gnt;
    assign load    = ~z_vld_q | z_rdy;
    assign xfer    = load & gnt_any & ~rst;
    assign s_rdy   = (load && !rst) ? gnt : '0;

    always_comb begin
        z_vld_d   = z_vld_q;
        z_bus_d   = z_bus_q;
        z_sel_d   = z_sel_q;
        ptr_d     = ptr_q;
        lock_d    = lock_q;
        lck_idx_d = lck_idx_q;

        if (load) begin
            if (gnt_any) begin
                z_vld_d = 1'b1;
                z_bus_d = src_bus;
                z_sel_d = gnt_idx;
            end else begin
                z_vld_d = 1'b0;
                z_bus_d = {BW{XZ}};
            end
        end

        if (xfer) begin
            ptr_d = (gnt_idx == SW'(SN - 1)) ? '0 : gnt_idx + SW'(1);
            // A beat without the last flag opens (or continues) a packet.
            if (LK) begin
                lock_d    = ~src_bus[BW-1];
                lck_idx_d = gnt_idx;
            end
        end

        if (!LK) begin
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z_vld_q   <= 1'b0;
            z_bus_q   <= {BW{XZ}};
            z_sel_q   <= '0;
            ptr_q     <= '0;
            lock_q    <= 1'b0;
            lck_idx_q <= '0;
        end else begin
            z_vld_q   <= z_vld_d;
            z_bus_q   <= z_bus_d;
            z_sel_q   <= z_sel_d;
            ptr_q     <= ptr_d;
            lock_q    <= lock_d;
            lck_idx_q <= lck_idx_d;
        end
    end

    assign z_vld = z_vld_q;
    assign z_bus = z_bus_q;
    assign z_sel = z_sel_q;

endmodule
